// File: rtl/uart_tx_interface.sv
// uart_tx_interface: 6809-facing 8N1 UART transmitter with holding register and THR-empty IRQ
module uart_tx_interface #(
  parameter int CLKS_PER_BIT = 4618,
  parameter int CNT_W = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_data_ce,
  input  logic       uart_status_ce,
  input  logic       i_RW,
  input  logic [7:0] i_DATA_BUS,
  output logic       o_UART_RX,
  output logic [7:0] o_DATA,
  output logic       o_IRQ
);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] baud_cnt, baud_n;
  logic [2:0] bit_cnt, bit_n;
  logic [7:0] thr, shift, shift_n, status;
  logic thr_full, overrun, irq_en, line_n, load, baud_end, accept;
  logic wr_data, wr_stat, rd_stat, rd_data;
  logic wr_data_q, wr_stat_q, rd_stat_q;
  assign wr_data = uart_data_ce & ~i_RW;
  assign wr_stat = uart_status_ce & ~i_RW;
  assign rd_stat = uart_status_ce & i_RW;
  assign rd_data = uart_data_ce & i_RW;
  assign baud_end = baud_cnt == CNT_W'(CLKS_PER_BIT - 1);
  // a write landing in the same cycle the shifter drains the THR is still accepted
  assign accept = wr_data & ~wr_data_q & (~thr_full | load);
  assign status = {4'b0, irq_en, overrun, state != IDLE, ~thr_full};
  // host side: strobe edge detection, holding register, flags, read data and IRQ
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_data_q <= 1'b0;
      wr_stat_q <= 1'b0;
      rd_stat_q <= 1'b0;
      thr <= 8'h00;
      thr_full <= 1'b0;
      overrun <= 1'b0;
      irq_en <= 1'b0;
      o_DATA <= 8'h00;
      o_IRQ <= 1'b0;
    end else begin
      wr_data_q <= wr_data;
      wr_stat_q <= wr_stat;
      rd_stat_q <= rd_stat;
      if (accept) thr <= i_DATA_BUS;
      thr_full <= accept | (thr_full & ~load);
      overrun <= (wr_data & ~wr_data_q & thr_full & ~load) | (overrun & ~(rd_stat & ~rd_stat_q));
      if (wr_stat & ~wr_stat_q) irq_en <= i_DATA_BUS[0];
      o_DATA <= rd_stat ? status : rd_data ? 8'h00 : o_DATA;
      o_IRQ <= irq_en & ~thr_full;
    end
  // shifter state register; reset drops any frame and idles the line high
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      baud_cnt <= '0;
      bit_cnt <= 3'd0;
      shift <= 8'h00;
      o_UART_RX <= 1'b1;
    end else begin
      state <= state_n;
      baud_cnt <= baud_n;
      bit_cnt <= bit_n;
      shift <= shift_n;
      o_UART_RX <= line_n;
    end
  // shifter next state: start bit, 8 data bits LSB first, stop bit, chaining straight into the next frame
  always_comb begin
    state_n = state;
    baud_n = baud_cnt + 1'b1;
    bit_n = bit_cnt;
    shift_n = shift;
    line_n = o_UART_RX;
    load = 1'b0;
    case (state)
      IDLE: begin
        baud_n = '0;
        line_n = ~thr_full;
        load = thr_full;
        state_n = thr_full ? START : IDLE;
        shift_n = thr_full ? thr : shift;
      end
      START: if (baud_end) begin
        state_n = DATA;
        baud_n = '0;
        bit_n = 3'd0;
        line_n = shift[0];
      end
      DATA: if (baud_end) begin
        baud_n = '0;
        state_n = bit_cnt == 3'd7 ? STOP : DATA;
        bit_n = bit_cnt + 3'd1;
        shift_n = shift >> 1;
        line_n = bit_cnt == 3'd7 ? 1'b1 : shift[1];
      end
      STOP: if (baud_end) begin
        baud_n = '0;
        load = thr_full;
        state_n = thr_full ? START : IDLE;
        shift_n = thr_full ? thr : shift;
        line_n = ~thr_full;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule
